spi_stream_slave: RTL
=====================

# spi_stream_slave

Parametrised SPI data-plane slave that replaces the fixed 8-bit, single-byte SPI receiver with configurable word width, runtime-selectable SPI mode and buffered RX/TX streams. It runs entirely in the system clock domain, oversampling the pin-level SPI signals. It sits between the SPI pins and the register file / stream consumers. Each transfer direction is buffered by a first-word-fall-through FIFO, with sticky overflow and underflow flags for the control plane.

## Interface
- DATA_W, 8: bits per SPI word, 4..32, MSB first.
- FIFO_DEPTH, 16: entries per RX and TX FIFO, power of two, ≥2.
- TX_FILL, '0: word shifted out when TX FIFO is empty at word start.
- LW = $clog2(FIFO_DEPTH+1): width of the level outputs.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock, asynchronous to clk.
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  master out, slave in.
- spi_miso  out  1  master in, slave out, registered.
- cfg_cpol, cfg_cpha  in  1 each  SPI mode, latched while CS is idle.
- rx_data  out  DATA_W  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pops RX FIFO when rx_valid && rx_ready.
- tx_data  in  DATA_W  word to push.
- tx_valid  in  1  push request.
- tx_ready  out  1  TX FIFO not full.
- rx_level, tx_level  out  LW each  FIFO occupancy.
- rx_overflow, tx_underflow  out  1 each  sticky error flags.
- clr_flags  in  1  clears both sticky flags.
- frame_active  out  1  synchronised CS is asserted and the block is armed.

## Operation
- spi_sclk, spi_cs and spi_mosi each pass through a 2-FF synchroniser, then a 1-cycle edge-detect register.
- Mode latch: mode is captured from cfg_cpol/cfg_cpha on every clk where synchronised CS is high. Changes during a frame are ignored.
- Sample edge:
  - rising for modes 0 and 3;
  - falling for modes 1 and 2.
  - The shift edge is the opposite edge.
- Arming:
  - After reset the block is disarmed.
  - It arms on the first clk where synchronised CS is seen high.
  - A CS already low at reset release is ignored until CS returns high.
- States:
  - IDLE → LOAD on synchronised CS falling while armed.
  - LOAD takes 1 cycle:
    - pop the TX FIFO into the shift register, or load TX_FILL and set tx_underflow if the FIFO is empty;
    - clear the bit counter;
    - go to SHIFT.
  - In SHIFT, each sample edge shifts spi_mosi into rx_shift and increments the bit counter.
  - In SHIFT, each shift edge moves the next TX bit to spi_miso.
  - On the sample edge where bit counter = DATA_W-1, the completed word is pushed to the RX FIFO, and the state goes to LOAD for the next word (continuous frames).
  - Any state → IDLE on synchronised CS rising. A partial word is discarded with no push, no flag, and the counter cleared.
- MISO:
  - CPHA=0: MSB is driven in the LOAD cycle.
  - CPHA=1: MSB is driven on the first shift (leading) edge.
  - In IDLE, spi_miso = 0.
- RX push when the FIFO is full: the word is dropped and rx_overflow is set. An external pop in the same cycle frees space, so the push succeeds with no flag.
- TX push when full (tx_valid && !tx_ready) is ignored and flags nothing.
- Sticky flags: clr_flags clears both. A set and a clr_flags in the same cycle leave the flag set.
- Levels count exactly 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

## Timing
- Reset values:
  - spi_miso=0, rx_valid=0, tx_ready=1, rx_level=0, tx_level=0;
  - flags=0, frame_active=0;
  - rx_data=0, state IDLE, disarmed.
- Pin-to-internal latency is 3 clk (2 sync + 1 edge detect).
- rx_valid rises 4 clk after the last sample edge at the pin.
- spi_miso updates ≤4 clk after the shift edge at the pin.
- Maximum SCLK is clk/8, with each SCLK phase ≥4 clk.
- CS setup to the first SCLK edge is ≥5 clk.
- FIFO push-to-pop visibility: a TX word pushed at cycle n is poppable by LOAD at n+1. An RX pop updates rx_data the next cycle.
- Simultaneous push and pop on either FIFO leaves the level unchanged.

## Test plan
- Mode 0, DATA_W=8, TX FIFO preloaded with 0xA5: master sends 0x3C → rx_data=0x3C, rx_valid=1, master receives 0xA5, tx_level 1→0.
- All four modes, DATA_W=16: send 0x8001 then 0x7FFE in one CS frame → two RX words in order, bit-exact in each mode.
- TX FIFO empty, TX_FILL=0xFF: one 8-bit word → MISO returns 0xFF, tx_underflow=1; clr_flags → 0.
- RX full (FIFO_DEPTH=4, rx_ready=0): send 5 words → rx_level=4, rx_overflow=1, first four words retained. Repeat with an rx_ready pulse on the 5th push cycle → no overflow.
- CS deasserted after 5 of 8 bits, then a full word 0x5A → only 0x5A appears, rx_level=1.
- rst held with CS low, then released with CS still low and SCLK toggling → no RX push until CS goes high then low again.

Source files
------------

// File: rtl/spi_stream_slave.sv
// SPI data-plane slave: oversampled pins, configurable word width and mode,
// first-word-fall-through RX/TX FIFOs with sticky overflow/underflow flags.

module spi_stream_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [PW-1:0]     level_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;

  // Pointer advance; the caller only pushes when space exists and pops when non-empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  // Head reads as zero when empty so the output is defined straight out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

module spi_stream_slave #(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0]  TX_FILL    = '0,
  localparam int unsigned       LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [LW-1:0]     rx_level,
  output logic [LW-1:0]     tx_level,
  output logic              rx_overflow,
  output logic              tx_underflow,
  input  logic              clr_flags,
  output logic              frame_active
);
  localparam int unsigned CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [2:0]        sclk_sync_q;
  logic [2:0]        cs_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              cpol_q, cpha_q, armed_q;
  state_t            state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-2:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              miso_q;
  logic              rx_push_q;
  logic [DATA_W-1:0] rx_word_q;
  logic              frame_active_q;
  logic              rx_overflow_q, tx_underflow_q;

  logic sclk_rise, sclk_fall, cs_s, cs_fall, cs_rise, mosi_s;
  logic sample_edge, shift_edge;
  logic rx_full, rx_empty, rx_pop, rx_push_ok, rx_ovf_set;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_unf_set;
  logic [DATA_W-1:0] tx_head, tx_word;

  // Two-flop synchronisers; the third sclk/cs stage is the edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_s      = cs_sync_q[1];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  // Mode follows cfg only while CS is idle; seeing CS idle also arms the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      armed_q <= 1'b0;
    end else if (cs_s) begin
      cpol_q  <= cfg_cpol;
      cpha_q  <= cfg_cpha;
      armed_q <= 1'b1;
    end
  end

  // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling.
  assign sample_edge = (cpol_q ~^ cpha_q) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cpol_q ~^ cpha_q) ? sclk_fall : sclk_rise;

  assign tx_pop     = (state_q == LOAD) && !cs_rise && !tx_empty;
  assign tx_unf_set = (state_q == LOAD) && !cs_rise && tx_empty;
  assign tx_word    = tx_empty ? TX_FILL : tx_head;

  // Frame FSM: word load, bit shifting, RX word hand-off and MISO drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
      rx_push_q      <= 1'b0;
      rx_word_q      <= '0;
      frame_active_q <= 1'b0;
    end else begin
      rx_push_q      <= 1'b0;
      frame_active_q <= armed_q & ~cs_s;
      if (cs_rise) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall && armed_q) state_q <= LOAD;
          end
          LOAD: begin
            bit_cnt_q <= '0;
            if (cpha_q) begin
              tx_shift_q <= tx_word;
            end else begin
              miso_q     <= tx_word[DATA_W-1];
              tx_shift_q <= tx_word << 1;
            end
            state_q <= SHIFT;
          end
          SHIFT: begin
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
              if (bit_cnt_q == LAST_BIT) begin
                rx_push_q <= 1'b1;
                rx_word_q <= {rx_shift_q, mosi_s};
                state_q   <= LOAD;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            // With CPHA=0 the MSB already left in LOAD, so the trailing edge that
            // closes the previous word (counter back at 0) must not advance.
            if (shift_edge && (cpha_q || bit_cnt_q != '0)) begin
              miso_q     <= tx_shift_q[DATA_W-1];
              tx_shift_q <= tx_shift_q << 1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_pop     = rx_ready && !rx_empty;
  assign rx_push_ok = rx_push_q && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_push_q && rx_full && !rx_pop;
  assign tx_push    = tx_valid && !tx_full;

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
    end else begin
      rx_overflow_q  <= (rx_overflow_q && !clr_flags) || rx_ovf_set;
      tx_underflow_q <= (tx_underflow_q && !clr_flags) || tx_unf_set;
    end
  end

  spi_stream_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push_ok),
    .data_i  (rx_word_q),
    .pop_i   (rx_pop),
    .data_o  (rx_data),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .level_o (rx_level)
  );

  spi_stream_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tx_push),
    .data_i  (tx_data),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .level_o (tx_level)
  );

  assign spi_miso     = miso_q;
  assign rx_valid     = !rx_empty;
  assign tx_ready     = !tx_full;
  assign rx_overflow  = rx_overflow_q;
  assign tx_underflow = tx_underflow_q;
  assign frame_active = frame_active_q;
endmodule
